segasys1_romarb: RTL and testbench
==================================

SEGASYS1_ROMARB -- requirements
Module: segasys1_romarb

Interface
REQ-001 Parameter TOUT, default 255, ROM response timeout in clocks; 0 disables the timeout.
REQ-002 Parameter TOVAL, default 8'hFF, data returned on timeout.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 r0_req  in  1  requester 0 (main CPU decrypt path) level request, held until r0_ack.
REQ-006 r0_ad  in  15  requester 0 ROM address, stable while r0_req is high.
REQ-007 r0_dt  out  8  requester 0 returned byte.
REQ-008 r0_ack  out  1  one-clock completion pulse for requester 0.
REQ-009 r1_req / r1_ad / r1_dt / r1_ack SHALL mirror REQ-005..008 for requester 1 (secondary fetch path).
REQ-010 rom_rd  out  1  one-clock ROM read strobe.
REQ-011 rom_ad  out  15  ROM address.
REQ-012 rom_dt  in  8  ROM data, valid with rom_vld.
REQ-013 rom_vld  in  1  ROM data-valid pulse.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; one transaction in flight at most.
REQ-015 IDLE: on any req high, latch grant id and address, go to ISSUE next clock; no request keeps IDLE.
REQ-016 ISSUE: rom_rd=1 for exactly this clock, rom_ad = latched address; go to WAIT.
REQ-017 WAIT: rom_vld=1 captures rom_dt into the granted requester's dt register, go to ACK; rom_ad holds the latched value.
REQ-018 ACK: granted ack=1 for one clock, then IDLE; the same requester, if still requesting, is eligible again from the next IDLE.
REQ-019 Minimum latency: req sampled at edge N gives ack high in cycle N+3 when rom_vld arrives in the cycle after rom_rd.
REQ-020 rx_dt SHALL hold its value until that requester's next ack; the other requester's dt is never modified.
REQ-021 rom_vld outside WAIT SHALL be ignored.
REQ-022 Timeout (TOUT>0): counter cleared on entering WAIT; after TOUT clocks in WAIT without rom_vld, load TOVAL and go to ACK.
REQ-023 Counter width SHALL be ceil(log2(TOUT+1)) bits, saturating, no wrap.
REQ-024 A req deasserted mid-transaction SHALL NOT abort it; the ack still pulses and the requester ignores it.
REQ-025 Simultaneous requests in IDLE resolve per REQ-029/030; the loser waits and is granted at the next IDLE.

Reset
REQ-026 reset SHALL force IDLE, rom_rd=0, rom_ad=0, r0_ack=r1_ack=0, r0_dt=r1_dt=8'h00, timeout counter 0, last-grant=1.
REQ-027 Reset mid-transaction SHALL drop the transaction with no ack; a late rom_vld after reset release is ignored (REQ-021).
REQ-028 First grant after reset SHALL occur no earlier than the first posedge with reset low.

Configuration
REQ-029 Macro SEGASYS1_ROMARB_RR_EN defined: round-robin; on a tie, grant the requester not granted last (requester 0 first after reset).
REQ-030 Macro undefined: fixed priority, requester 0 always wins ties; requester 1 may starve.

Structure
REQ-031 Shared package segasys1_pkg SHALL hold the FSM state enum, requester id constants (RQ_MAIN=0, RQ_SUB=1) and the ROM address width constant (15).
REQ-032 Grant selection SHALL be one sub-module, segasys1_romarb_pick (inputs: two reqs, last-grant; output: grant id, valid); all else stays in segasys1_romarb.

Verification
REQ-033 r0_req, r0_ad=15'h1234, rom_vld+rom_dt=8'h5A one clock after rom_rd -> rom_ad=15'h1234, r0_ack in cycle N+3, r0_dt=8'h5A held.
REQ-034 r0 and r1 requesting together, reqs held -> RR_EN: grants alternate 0,1,0,1; without: r0 every transaction, r1_ack never.
REQ-035 TOUT=4, rom_vld never asserted -> granted ack 4 clocks after entering WAIT, dt=8'hFF.
REQ-036 reset asserted in WAIT, then rom_vld pulse after release -> no ack, both dt=8'h00, FSM IDLE.
REQ-037 r1 grants with rom_dt=8'h3C, then r0 grants with rom_dt=8'hC3 -> r1_dt stays 8'h3C, r0_dt=8'hC3; stray rom_vld in IDLE changes nothing.

Source files
------------

// File: rtl/segasys1_pkg.sv
// Shared definitions for the System 1 ROM arbiter: FSM states, requester ids,
// ROM address width and the timeout counter width helper.
package segasys1_pkg;

    localparam int unsigned ROM_AW = 15;

    localparam logic RQ_MAIN = 1'b0;
    localparam logic RQ_SUB  = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StAck
    } arb_state_e;

    // ceil(log2(tout+1)), kept at least 1 bit so a disabled timeout still elaborates.
    function automatic int unsigned cnt_width(input int unsigned tout);
        return (tout < 1) ? 1 : $clog2(tout + 1);
    endfunction

endpackage

// File: rtl/segasys1_romarb_pick.sv
// Grant selection for the two ROM requesters.
// SEGASYS1_ROMARB_RR_EN selects round-robin on ties; otherwise requester 0 wins.
module segasys1_romarb_pick
    import segasys1_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic gnt_o,
    output logic valid_o
);

`ifndef SEGASYS1_ROMARB_RR_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        valid_o = req0_i | req1_i;
        gnt_o   = RQ_MAIN;
        if (req0_i && req1_i) begin
`ifdef SEGASYS1_ROMARB_RR_EN
            gnt_o = ~last_i;
`else
            gnt_o = RQ_MAIN;
`endif
        end else if (req1_i) begin
            gnt_o = RQ_SUB;
        end
    end

endmodule

// File: rtl/segasys1_romarb.sv
// Two-requester ROM arbiter with one transaction in flight and optional response timeout.
// Tie-break policy chosen by SEGASYS1_ROMARB_RR_EN (see segasys1_romarb_pick).
module segasys1_romarb
    import segasys1_pkg::*;
#(
    parameter int unsigned TOUT  = 255,
    parameter logic [7:0]  TOVAL = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic [ROM_AW-1:0] r0_ad,
    output logic [7:0]        r0_dt,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic [ROM_AW-1:0] r1_ad,
    output logic [7:0]        r1_dt,
    output logic              r1_ack,
    output logic              rom_rd,
    output logic [ROM_AW-1:0] rom_ad,
    input  logic [7:0]        rom_dt,
    input  logic              rom_vld
);

    localparam int unsigned     CntW    = cnt_width(TOUT);
    localparam logic [CntW-1:0] CntMax  = CntW'(TOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TOUT - 1);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        r0_dt_q, r0_dt_d;
    logic [7:0]        r1_dt_q, r1_dt_d;
    logic              pick_gnt, pick_vld;
    logic              timeout;

    segasys1_romarb_pick u_pick (
        .req0_i  (r0_req),
        .req1_i  (r1_req),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_vld)
    );

    assign timeout = (TOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        r0_dt_d = r0_dt_q;
        r1_dt_d = r1_dt_q;
        case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    gnt_d   = pick_gnt;
                    last_d  = pick_gnt;
                    addr_d  = (pick_gnt == RQ_SUB) ? r1_ad : r0_ad;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (rom_vld || timeout) begin
                    // A real response beats a coincident timeout.
                    if (gnt_q == RQ_SUB) begin
                        r1_dt_d = rom_vld ? rom_dt : TOVAL;
                    end else begin
                        r0_dt_d = rom_vld ? rom_dt : TOVAL;
                    end
                    state_d = StAck;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= RQ_MAIN;
            last_q  <= RQ_SUB;
            addr_q  <= '0;
            cnt_q   <= '0;
            r0_dt_q <= 8'h00;
            r1_dt_q <= 8'h00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            r0_dt_q <= r0_dt_d;
            r1_dt_q <= r1_dt_d;
        end
    end

    assign rom_rd = (state_q == StIssue);
    assign rom_ad = addr_q;
    assign r0_ack = (state_q == StAck) && (gnt_q == RQ_MAIN);
    assign r1_ack = (state_q == StAck) && (gnt_q == RQ_SUB);
    assign r0_dt  = r0_dt_q;
    assign r1_dt  = r1_dt_q;

endmodule

// File: tb/tb_segasys1_romarb.sv
// Directed, table-driven bench for segasys1_romarb with TOUT=4.
module tb_segasys1_romarb;
    import segasys1_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r1_req, rom_vld, rom_rd, r0_ack, r1_ack;
    logic [14:0] r0_ad, r1_ad, rom_ad;
    logic [7:0]  r0_dt, r1_dt, rom_dt;

    int n_vec = 0;
    int n_err = 0;

    segasys1_romarb #(
        .TOUT  (4),
        .TOVAL (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .r0_req  (r0_req),
        .r0_ad   (r0_ad),
        .r0_dt   (r0_dt),
        .r0_ack  (r0_ack),
        .r1_req  (r1_req),
        .r1_ad   (r1_ad),
        .r1_dt   (r1_dt),
        .r1_ack  (r1_ack),
        .rom_rd  (rom_rd),
        .rom_ad  (rom_ad),
        .rom_dt  (rom_dt),
        .rom_vld (rom_vld)
    );

    always #5 clk = ~clk;

    // Inputs applied before an edge, outputs expected after it.
    typedef struct packed {
        logic        r0_req;
        logic [14:0] r0_ad;
        logic        r1_req;
        logic [14:0] r1_ad;
        logic        vld;
        logic [7:0]  dt;
        logic        e_rd;
        logic [14:0] e_ad;
        logic        e_a0;
        logic        e_a1;
        logic [7:0]  e_d0;
        logic [7:0]  e_d1;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({rom_rd, rom_ad, r0_ack, r1_ack, r0_dt, r1_dt});
    endfunction

    int got_id[4];
    int n_got;
    int n_ack;

    initial begin
        //            r0q r0ad      r1q r1ad      vld dt     rd ad        a0 a1 d0     d1
        tbl[0]  = '{1'b1, 15'h1234, 1'b0, 15'h0,    1'b0, 8'h00, 1'b1, 15'h1234, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 15'h1234, 1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h1234, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{1'b1, 15'h1234, 1'b0, 15'h0,    1'b1, 8'h5A, 1'b0, 15'h1234, 1'b1, 1'b0, 8'h5A, 8'h00};
        tbl[3]  = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h1234, 1'b0, 1'b0, 8'h5A, 8'h00};
        tbl[4]  = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b1, 8'h77, 1'b0, 15'h1234, 1'b0, 1'b0, 8'h5A, 8'h00};
        tbl[5]  = '{1'b0, 15'h0,    1'b1, 15'h0ABC, 1'b0, 8'h00, 1'b1, 15'h0ABC, 1'b0, 1'b0, 8'h5A, 8'h00};
        tbl[6]  = '{1'b0, 15'h0,    1'b1, 15'h0ABC, 1'b1, 8'h3C, 1'b0, 15'h0ABC, 1'b0, 1'b0, 8'h5A, 8'h00};
        tbl[7]  = '{1'b0, 15'h0,    1'b1, 15'h0ABC, 1'b0, 8'h00, 1'b0, 15'h0ABC, 1'b0, 1'b0, 8'h5A, 8'h00};
        tbl[8]  = '{1'b0, 15'h0,    1'b1, 15'h0ABC, 1'b1, 8'h3C, 1'b0, 15'h0ABC, 1'b0, 1'b1, 8'h5A, 8'h3C};
        tbl[9]  = '{1'b1, 15'h7FFF, 1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h0ABC, 1'b0, 1'b0, 8'h5A, 8'h3C};
        tbl[10] = '{1'b1, 15'h7FFF, 1'b0, 15'h0,    1'b0, 8'h00, 1'b1, 15'h7FFF, 1'b0, 1'b0, 8'h5A, 8'h3C};
        tbl[11] = '{1'b1, 15'h7FFF, 1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h7FFF, 1'b0, 1'b0, 8'h5A, 8'h3C};
        tbl[12] = '{1'b1, 15'h7FFF, 1'b0, 15'h0,    1'b1, 8'hC3, 1'b0, 15'h7FFF, 1'b1, 1'b0, 8'hC3, 8'h3C};
        tbl[13] = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h7FFF, 1'b0, 1'b0, 8'hC3, 8'h3C};
        tbl[14] = '{1'b0, 15'h0,    1'b1, 15'h0001, 1'b0, 8'h00, 1'b1, 15'h0001, 1'b0, 1'b0, 8'hC3, 8'h3C};
        tbl[15] = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h0001, 1'b0, 1'b0, 8'hC3, 8'h3C};
        tbl[16] = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h0001, 1'b0, 1'b0, 8'hC3, 8'h3C};
        tbl[17] = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h0001, 1'b0, 1'b0, 8'hC3, 8'h3C};
        tbl[18] = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h0001, 1'b0, 1'b0, 8'hC3, 8'h3C};
        tbl[19] = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h0001, 1'b0, 1'b1, 8'hC3, 8'hFF};
        tbl[20] = '{1'b0, 15'h0,    1'b0, 15'h0,    1'b0, 8'h00, 1'b0, 15'h0001, 1'b0, 1'b0, 8'hC3, 8'hFF};

        reset = 1'b1;
        {r0_req, r1_req, rom_vld} = '0;
        r0_ad = '0; r1_ad = '0; rom_dt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", outs(), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            r0_req  = tbl[i].r0_req;
            r0_ad   = tbl[i].r0_ad;
            r1_req  = tbl[i].r1_req;
            r1_ad   = tbl[i].r1_ad;
            rom_vld = tbl[i].vld;
            rom_dt  = tbl[i].dt;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                64'({tbl[i].e_rd, tbl[i].e_ad, tbl[i].e_a0, tbl[i].e_a1, tbl[i].e_d0,
                     tbl[i].e_d1}));
        end

        // Held simultaneous requests from a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r0_req = 1'b1; r0_ad = 15'h0100;
        r1_req = 1'b1; r1_ad = 15'h0200;
        rom_vld = 1'b1; rom_dt = 8'h11;
        n_got = 0;
        for (int c = 0; c < 40 && n_got < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (r0_ack || r1_ack) begin
                got_id[n_got] = r1_ack ? 1 : 0;
                n_got++;
            end
        end
        r0_req = 1'b0; r1_req = 1'b0; rom_vld = 1'b0;
        chk("tie_ack_count", 64'(n_got), 64'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef SEGASYS1_ROMARB_RR_EN
            chk($sformatf("tie_grant%0d", k), 64'(got_id[k]), 64'(k % 2));
`else
            chk($sformatf("tie_grant%0d", k), 64'(got_id[k]), 64'd0);
`endif
        end
        @(posedge clk);
        @(negedge clk);

        // Reset while waiting on the ROM, then a late response.
        r0_req = 1'b1; r0_ad = 15'h0055;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("wait_state", 64'(dut.state_q), 64'(StWait));
        chk("wait_addr", 64'(rom_ad), 64'h0055);
        reset = 1'b1;
        r0_req = 1'b0;
        #2;
        chk("async_reset", outs(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rom_vld = 1'b1; rom_dt = 8'hAA;
        n_ack = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            rom_vld = 1'b0;
            if (r0_ack || r1_ack || rom_rd) n_ack++;
        end
        chk("late_vld_no_ack", 64'(n_ack), 64'd0);
        chk("late_vld_dt", 64'({r0_dt, r1_dt}), 64'h0000);
        chk("late_vld_idle", 64'(dut.state_q), 64'(StIdle));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
